reg_register_int_ctrl: RTL and testbench
========================================

// Module: reg_register_int_ctrl
// PURPOSE
//  Parametrised interrupt controller register block: NUM_CH channels, each with enable, sticky status and software set.
//  Four registers sit behind one select via a 2-bit address: ENABLE, STATUS, SET and PENDING.
//  Captures hardware event inputs, supports W1C clear and W1S set, and drives one aggregated registered irq.
//  Sits in the register slice beside the other reg_register_* blocks and is driven by the same sel/rd-wr bus.
// PARAMETERS
//  REG_WIDTH  32  bus data width
//  NUM_CH     8   interrupt channels, 1..REG_WIDTH; bits [REG_WIDTH-1:NUM_CH] are reserved and read 0
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          asynchronous active-low reset
//  reg_wr_sel   in   1          block select
//  reg_wr_rd    in   1          1: write, 0: read
//  reg_addr     in   2          0 ENABLE, 1 STATUS, 2 SET, 3 PENDING
//  reg_wr_data  in   REG_WIDTH  write data
//  reg_rd_out   out  REG_WIDTH  registered read data
//  hw_event     in   NUM_CH     per-channel hardware interrupt source
//  int_enable   out  NUM_CH     current ENABLE register value
//  int_status   out  NUM_CH     current sticky STATUS value
//  irq          out  1          registered OR of (STATUS & ENABLE)
//  reg_wr_pulse out  1          one-cycle strobe, 1 clk after any write
//  reg_rd_pulse out  1          one-cycle strobe, 1 clk after any read
// BEHAVIOUR
//  Reset: rst_n is asynchronous, active-low; clock is clk.
//   - All registers, reg_rd_out, irq and both pulses reset to 0.
//   - Asserting rst_n mid-operation clears everything immediately, including pending status.
//  Access: write = sel & rd_wr; read = sel & ~rd_wr. Each is qualified per address.
//  ENABLE (RW): on write, enable <= wr_data[NUM_CH-1:0].
//  STATUS (W1C): on write, bits with wr_data=1 clear; bits with wr_data=0 are unchanged.
//  SET (W1S): on write, status |= wr_data[NUM_CH-1:0]. Reads return 0.
//  PENDING (RO): reads return status & enable. Writes are ignored.
//  Capture: each cycle, status <= (status & ~w1c_mask) | set_mask | event_capture.
//   - event_capture = hw_event (level) in the base build.
//   - Status captures regardless of enable; enable gates only irq and PENDING.
//   - An event and a W1C on the same bit in the same cycle leave status 1: set wins, no event is lost.
//  Read latency: 1 clk.
//   - reg_rd_out is captured on the edge where the read is sampled and is held until the next read.
//   - A read returns pre-edge register values; an update in the same cycle is not visible.
//  Strobes: reg_wr_pulse and reg_rd_pulse are the access conditions delayed by one flop.
//  irq <= |(status_next & enable_next).
//   - irq asserts 1 clk after an event or SET.
//   - irq deasserts 1 clk after the W1C or ENABLE write that removes the last pending bit.
//  Reserved read bits return 0. Write data above NUM_CH is ignored.
// CONFIGURATION
//  REG_INT_EDGE_EN defined:
//   - event_capture = hw_event & ~hw_event_d, using a per-channel delay flop that resets to 0.
//   - A held-high source sets status once. After W1C, status stays 0 until a new rising edge.
//  REG_INT_EDGE_EN undefined:
//   - Level capture. A held-high source re-sets status every cycle, so W1C cannot clear it.
// STRUCTURE
//  Package reg_int_pkg holds:
//   - address localparams REG_INT_ADDR_ENABLE=0, _STATUS=1, _SET=2, _PENDING=3;
//   - typedef reg_int_addr_t (logic [1:0]).
//  Sub-module reg_int_chan: one channel's status flop, optional edge detector, W1C/W1S merge and enable flop.
//   - Instantiated NUM_CH times via generate.
//   - The top level holds address decode, the read mux/register, the strobes and the irq reduction.
// TESTING
//  1. Reset, then read all 4 addresses -> reg_rd_out = 0 for each, irq = 0, pulses = 0.
//  2. Write ENABLE=0x05, pulse hw_event[0] for 1 clk -> STATUS=0x01, PENDING=0x01, irq=1 one clk after the event.
//  3. W1C STATUS with 0x01 -> STATUS=0x00 and irq=0 one clk later; reg_wr_pulse high for exactly 1 clk.
//  4. Write SET=0x82 with ENABLE=0x00 -> STATUS=0x82, PENDING=0, irq=0; then write ENABLE=0x80 -> irq=1.
//  5. hw_event[3] held high, same-cycle W1C of bit 3 ->
//     - base build: STATUS bit 3 stays 1;
//     - with REG_INT_EDGE_EN: it stays 1 only in the event cycle, and a later W1C clears it.
//  6. Assert rst_n low for 1 clk while irq=1 and STATUS=0xFF -> all outputs 0 immediately;
//     write data 0xFFFF_FF00 to ENABLE with NUM_CH=8 -> ENABLE reads 0.

Source files
------------

// File: rtl/reg_int_pkg.sv
// Shared definitions for the reg_register_int_ctrl interrupt register block.
// Register map: 0 ENABLE (RW), 1 STATUS (W1C), 2 SET (W1S, reads 0), 3 PENDING (RO).
// No ports. Imported by reg_int_chan and reg_register_int_ctrl.
package reg_int_pkg;

  typedef logic [1:0] reg_int_addr_t;

  localparam reg_int_addr_t REG_INT_ADDR_ENABLE  = 2'd0;
  localparam reg_int_addr_t REG_INT_ADDR_STATUS  = 2'd1;
  localparam reg_int_addr_t REG_INT_ADDR_SET     = 2'd2;
  localparam reg_int_addr_t REG_INT_ADDR_PENDING = 2'd3;

endpackage

// File: rtl/reg_int_chan.sv
// Purpose: one interrupt channel - sticky status flop with W1C/W1S merge, enable flop.
// Latency: status/enable update on the edge the event or write is sampled.
// Backpressure: none; every event and write is absorbed in the cycle it arrives.
// Ports: clk, rst_n (async active-low); hw_event source; en_wr/en_dat enable write;
//        w1c/w1s per-channel clear/set strobes; enable/status current values;
//        enable_next/status_next the values about to be loaded (used for registered irq).
// Config: REG_INT_EDGE_EN selects rising-edge capture; default is level capture.
module reg_int_chan
  import reg_int_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic hw_event,
  input  logic en_wr,
  input  logic en_dat,
  input  logic w1c,
  input  logic w1s,
  output logic enable,
  output logic status,
  output logic enable_next,
  output logic status_next
);

  logic event_capture;

`ifdef REG_INT_EDGE_EN
  logic hw_event_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hw_event_d <= 1'b0;
    else        hw_event_d <= hw_event;
  end

  // A held-high source sets status only on its rising edge, so W1C can clear it.
  assign event_capture = hw_event & ~hw_event_d;
`else
  // Level capture: a held-high source keeps re-setting status.
  assign event_capture = hw_event;
`endif

  // Set terms are OR'd after the clear so a same-cycle event/W1S wins over W1C.
  assign status_next = (status & ~w1c) | w1s | event_capture;
  assign enable_next = en_wr ? en_dat : enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= 1'b0;
      enable <= 1'b0;
    end else begin
      status <= status_next;
      enable <= enable_next;
    end
  end

endmodule

// File: rtl/reg_register_int_ctrl.sv
// Purpose: NUM_CH-channel interrupt controller register block with aggregated irq.
// Latency: read data 1 clk after the read is sampled; irq and access strobes 1 clk after cause.
// Backpressure: none; the block accepts a bus access every cycle.
// Ports: clk, rst_n (async active-low); reg_wr_sel/reg_wr_rd/reg_addr/reg_wr_data bus;
//        reg_rd_out registered read data (held between reads); hw_event sources;
//        int_enable/int_status current registers; irq registered OR of status & enable;
//        reg_wr_pulse/reg_rd_pulse one-cycle access strobes.
// Config: define REG_INT_EDGE_EN for rising-edge event capture (default: level capture).
module reg_register_int_ctrl
  import reg_int_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int NUM_CH    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reg_wr_sel,
  input  logic                 reg_wr_rd,
  input  logic [1:0]           reg_addr,
  input  logic [REG_WIDTH-1:0] reg_wr_data,
  output logic [REG_WIDTH-1:0] reg_rd_out,
  input  logic [NUM_CH-1:0]    hw_event,
  output logic [NUM_CH-1:0]    int_enable,
  output logic [NUM_CH-1:0]    int_status,
  output logic                 irq,
  output logic                 reg_wr_pulse,
  output logic                 reg_rd_pulse
);

  logic                 wr_acc;
  logic                 rd_acc;
  logic                 en_wr;
  logic [NUM_CH-1:0]    wr_ch;
  logic [NUM_CH-1:0]    w1c_mask;
  logic [NUM_CH-1:0]    w1s_mask;
  logic [NUM_CH-1:0]    status_next;
  logic [NUM_CH-1:0]    enable_next;
  logic [REG_WIDTH-1:0] rd_data;
  logic                 unused_wr_bits;

  assign wr_acc = reg_wr_sel &  reg_wr_rd;
  assign rd_acc = reg_wr_sel & ~reg_wr_rd;

  // Data bits above NUM_CH are reserved and intentionally dropped.
  assign wr_ch          = reg_wr_data[NUM_CH-1:0];
  assign unused_wr_bits = ^reg_wr_data;

  assign en_wr    = wr_acc && (reg_addr == REG_INT_ADDR_ENABLE);
  assign w1c_mask = (wr_acc && (reg_addr == REG_INT_ADDR_STATUS)) ? wr_ch : '0;
  assign w1s_mask = (wr_acc && (reg_addr == REG_INT_ADDR_SET))    ? wr_ch : '0;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    reg_int_chan u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .hw_event    (hw_event[ch]),
      .en_wr       (en_wr),
      .en_dat      (wr_ch[ch]),
      .w1c         (w1c_mask[ch]),
      .w1s         (w1s_mask[ch]),
      .enable      (int_enable[ch]),
      .status      (int_status[ch]),
      .enable_next (enable_next[ch]),
      .status_next (status_next[ch])
    );
  end

  // Read mux uses the pre-edge register values; reserved bits stay 0.
  always_comb begin
    rd_data = '0;
    case (reg_addr)
      REG_INT_ADDR_ENABLE:  rd_data[NUM_CH-1:0] = int_enable;
      REG_INT_ADDR_STATUS:  rd_data[NUM_CH-1:0] = int_status;
      REG_INT_ADDR_PENDING: rd_data[NUM_CH-1:0] = int_status & int_enable;
      default:              rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_rd_out   <= '0;
      irq          <= 1'b0;
      reg_wr_pulse <= 1'b0;
      reg_rd_pulse <= 1'b0;
    end else begin
      if (rd_acc) reg_rd_out <= rd_data;
      // Built from next-state values so irq tracks the registers with no extra lag.
      irq          <= |(status_next & enable_next);
      reg_wr_pulse <= wr_acc;
      reg_rd_pulse <= rd_acc;
    end
  end

endmodule

// File: tb/tb_reg_register_int_ctrl.sv
// Directed bench for reg_register_int_ctrl (REG_WIDTH=32, NUM_CH=8).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_reg_register_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_wr_sel;
  logic        reg_wr_rd;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_out;
  logic [7:0]  hw_event;
  logic [7:0]  int_enable;
  logic [7:0]  int_status;
  logic        irq;
  logic        reg_wr_pulse;
  logic        reg_rd_pulse;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  reg_register_int_ctrl #(.REG_WIDTH(32), .NUM_CH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_wr_sel   (reg_wr_sel),
    .reg_wr_rd    (reg_wr_rd),
    .reg_addr     (reg_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_rd_out   (reg_rd_out),
    .hw_event     (hw_event),
    .int_enable   (int_enable),
    .int_status   (int_status),
    .irq          (irq),
    .reg_wr_pulse (reg_wr_pulse),
    .reg_rd_pulse (reg_rd_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called at a falling edge; returns at the next falling edge with the access done.
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    reg_wr_sel  = 1'b1;
    reg_wr_rd   = 1'b1;
    reg_addr    = a;
    reg_wr_data = d;
    @(negedge clk);
    reg_wr_sel  = 1'b0;
    reg_wr_data = '0;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    reg_wr_sel = 1'b1;
    reg_wr_rd  = 1'b0;
    reg_addr   = a;
    @(negedge clk);
    reg_wr_sel = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    reg_wr_sel  = 1'b0;
    reg_wr_rd   = 1'b0;
    reg_addr    = 2'd0;
    reg_wr_data = '0;
    hw_event    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. reset state and reads of every address
    check("rst_irq", irq, 0);
    check("rst_rd_out", reg_rd_out, 0);
    check("rst_wr_pulse", reg_wr_pulse, 0);
    check("rst_rd_pulse", reg_rd_pulse, 0);
    check("rst_status", int_status, 0);
    check("rst_enable", int_enable, 0);
    for (int a = 0; a < 4; a++) begin
      bus_rd(a[1:0]);
      check("rst_read", reg_rd_out, 0);
      check("rst_read_pulse", reg_rd_pulse, 1);
    end
    @(negedge clk);
    check("rd_pulse_one_clk", reg_rd_pulse, 0);

    // 2. enable 0x05, one-cycle event on channel 0
    bus_wr(2'd0, 32'h05);
    check("en_write", int_enable, 8'h05);
    check("en_wr_pulse", reg_wr_pulse, 1);
    check("irq_before_event", irq, 0);
    hw_event = 8'h01;
    @(negedge clk);
    hw_event = 8'h00;
    check("event_status", int_status, 8'h01);
    check("event_irq", irq, 1);
    bus_rd(2'd1);
    check("read_status", reg_rd_out, 32'h01);
    bus_rd(2'd3);
    check("read_pending", reg_rd_out, 32'h01);
    bus_rd(2'd0);
    check("read_enable", reg_rd_out, 32'h05);

    // 3. W1C clears status and drops irq
    bus_wr(2'd1, 32'h01);
    check("w1c_status", int_status, 8'h00);
    check("w1c_irq", irq, 0);
    check("w1c_wr_pulse", reg_wr_pulse, 1);
    @(negedge clk);
    check("wr_pulse_one_clk", reg_wr_pulse, 0);
    check("rd_out_held", reg_rd_out, 32'h05);

    // 4. SET with enable off, then enable the top channel
    bus_wr(2'd0, 32'h00);
    bus_wr(2'd2, 32'h82);
    check("set_status", int_status, 8'h82);
    check("set_irq_masked", irq, 0);
    bus_rd(2'd3);
    check("set_pending_masked", reg_rd_out, 0);
    bus_rd(2'd2);
    check("set_reads_zero", reg_rd_out, 0);
    bus_rd(2'd1);
    check("set_read_status", reg_rd_out, 32'h82);
    bus_wr(2'd0, 32'h80);
    check("enable_irq", irq, 1);
    bus_rd(2'd3);
    check("enable_pending", reg_rd_out, 32'h80);

    // 5. held event on channel 3 against W1C of bit 3
    hw_event = 8'h08;
    bus_wr(2'd1, 32'h08);
    check("evt_w1c_same_cycle", int_status, 8'h8A);
    bus_wr(2'd1, 32'h08);
`ifdef REG_INT_EDGE_EN
    check("held_w1c_edge", int_status, 8'h82);
`else
    check("held_w1c_level", int_status, 8'h8A);
`endif
    hw_event = 8'h00;
    bus_wr(2'd1, 32'h08);
    check("released_w1c", int_status, 8'h82);
    check("irq_still_set", irq, 1);

    // read returns pre-edge value while an event lands in the same cycle
    hw_event = 8'h01;
    bus_rd(2'd1);
    hw_event = 8'h00;
    check("read_pre_edge", reg_rd_out, 32'h82);
    check("event_after_read", int_status, 8'h83);
    bus_wr(2'd1, 32'h01);

    // 6. asynchronous reset with everything pending
    bus_wr(2'd2, 32'hFF);
    bus_wr(2'd0, 32'hFF);
    check("all_status", int_status, 8'hFF);
    check("all_irq", irq, 1);
    bus_rd(2'd1);
    check("all_read", reg_rd_out, 32'h000000FF);
    #1 rst_n = 1'b0;
    #1;
    check("arst_irq", irq, 0);
    check("arst_status", int_status, 0);
    check("arst_enable", int_enable, 0);
    check("arst_rd_out", reg_rd_out, 0);
    check("arst_rd_pulse", reg_rd_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_wr(2'd0, 32'hFFFF_FF00);
    check("rsvd_enable", int_enable, 0);
    bus_rd(2'd0);
    check("rsvd_enable_read", reg_rd_out, 0);
    bus_rd(2'd1);
    check("post_rst_status", reg_rd_out, 0);
    bus_wr(2'd0, 32'hFFFF_FFFF);
    bus_rd(2'd0);
    check("rsvd_bits_zero", reg_rd_out, 32'h000000FF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
